// File: rtl/attention_score_engine_pkg.sv
// Shared types and helpers for the attention datapath.
// Used by the QKV projection and score stages.
package attn_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t WRITE = 2'd3;

    // Row-major offset computed at DATA_W, truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_off(
        input logic [ADDR_W-1:0] base,
        input logic [15:0]       row,
        input logic [15:0]       dim,
        input logic [15:0]       col
    );
        logic [DATA_W-1:0] full;
        full = DATA_W'(base)
             + DATA_W'(row) * DATA_W'(dim)
             + DATA_W'(col);
        return full[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/attention_score_engine_if.sv
// Start/ready control plus Q, K and S SRAM ports
// of the attention score engine.
interface attention_score_engine_if;
    import attn_pkg::*;

    logic              start;
    logic [15:0]       seq_len;
    logic [15:0]       d_k;
    logic              ready;
    logic [ADDR_W-1:0] q_read_address;
    logic [DATA_W-1:0] q_read_data;
    logic [ADDR_W-1:0] k_read_address;
    logic [DATA_W-1:0] k_read_data;
    logic              s_write_enable;
    logic [ADDR_W-1:0] s_write_address;
    logic [DATA_W-1:0] s_write_data;

    modport master (
        output start, seq_len, d_k,
        output q_read_data, k_read_data,
        input  ready,
        input  q_read_address, k_read_address,
        input  s_write_enable, s_write_address, s_write_data
    );

    modport slave (
        input  start, seq_len, d_k,
        input  q_read_data, k_read_data,
        output ready,
        output q_read_address, k_read_address,
        output s_write_enable, s_write_address, s_write_data
    );

endinterface

// File: rtl/attention_score_engine_score_mac.sv
// Multiply-accumulate with a one-cycle valid pipe that
// tracks SRAM read latency; products and sums wrap.
module score_mac
    import attn_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         issue,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_next
);

    logic         valid;
    logic [W-1:0] acc;
    logic [W-1:0] prod;

    assign prod = a * b;

    always_comb begin
        acc_next = acc;
        if (clear)
            acc_next = '0;
        else if (valid)
            acc_next = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            acc   <= '0;
        end else begin
            valid <= issue;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/attention_score_engine.sv
// Score stage: S = Q x K^T with one MAC, D+2 cycles
// per element, S written row-major to result SRAM.
module attention_score_engine
    import attn_pkg::*;
#(
    parameter logic [ADDR_W-1:0] Q_BASE = 16'd1,
    parameter logic [ADDR_W-1:0] K_BASE = 16'd0,
    parameter logic [ADDR_W-1:0] S_BASE = 16'd12
) (
    input logic                    clk,
    input logic                    reset,
    attention_score_engine_if.slave bus
);

    state_t            state, state_nx;
    logic [15:0]       n, n_nx;
    logic [15:0]       d, d_nx;
    logic [15:0]       i, i_nx;
    logic [15:0]       j, j_nx;
    logic [15:0]       k, k_nx;
    logic              accept;
    logic              ready_q;
    logic [ADDR_W-1:0] q_addr, k_addr, s_addr;
    logic              s_we;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] acc_nx;

    assign accept = (state == IDLE) && bus.start && ready_q;

    always_comb begin
        state_nx = state;
        n_nx     = n;
        d_nx     = d;
        i_nx     = i;
        j_nx     = j;
        k_nx     = k;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    n_nx = bus.seq_len;
                    d_nx = bus.d_k;
                    i_nx = '0;
                    j_nx = '0;
                    k_nx = '0;
                    if (bus.seq_len != 16'd0 && bus.d_k != 16'd0)
                        state_nx = ISSUE;
                end
            end
            ISSUE: begin
                k_nx = k + 16'd1;
                if (k == d - 16'd1)
                    state_nx = WAIT;
            end
            WAIT: state_nx = WRITE;
            WRITE: begin
                k_nx     = '0;
                state_nx = ISSUE;
                if (j == n - 16'd1) begin
                    j_nx = '0;
                    if (i == n - 16'd1)
                        state_nx = IDLE;
                    else
                        i_nx = i + 16'd1;
                end else begin
                    j_nx = j + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they
    // line up with the cycle the FSM is in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            n       <= '0;
            d       <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            ready_q <= 1'b0;
            q_addr  <= '0;
            k_addr  <= '0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_data  <= '0;
        end else begin
            state   <= state_nx;
            n       <= n_nx;
            d       <= d_nx;
            i       <= i_nx;
            j       <= j_nx;
            k       <= k_nx;
            ready_q <= (state_nx == IDLE);
            s_we    <= (state_nx == WRITE);
            if (state_nx == ISSUE) begin
                q_addr <= addr_off(Q_BASE, i_nx, d_nx, k_nx);
                k_addr <= addr_off(K_BASE, j_nx, d_nx, k_nx);
            end
            if (state_nx == WRITE) begin
                s_addr <= addr_off(S_BASE, i_nx, n_nx, j_nx);
                s_data <= acc_nx;
            end
        end
    end

    score_mac #(.W(DATA_W)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept || (state == WRITE)),
        .issue    (state == ISSUE),
        .a        (bus.q_read_data),
        .b        (bus.k_read_data),
        .acc_next (acc_nx)
    );

    assign bus.ready           = ready_q;
    assign bus.q_read_address  = q_addr;
    assign bus.k_read_address  = k_addr;
    assign bus.s_write_enable  = s_we;
    assign bus.s_write_address = s_addr;
    assign bus.s_write_data    = s_data;

endmodule
